svm_result_collector: RTL and testbench

Collects the per-instance decision values from the MAC array, adds the model bias with saturation, and presents a registered batch of results plus class labels behind a valid/ready handshake. It sits between the MAC accumulator output and the host/readback logic. Compared with the previous collector it adds:

- beat counting gated by `mac_valid` (the MAC may stall),
- bias addition with saturation,
- sign labels,
- an output handshake,
- abort,
- start-error reporting.

---
 rtl/svm_result_collector.sv | 159 +++++++++++++++
 tb/tb_svm_result_collector.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_result_collector.sv
// Collects per-instance MAC decision values, adds the model bias with saturation,
// and holds the finished batch plus sign labels behind a valid/ready handshake.
module svm_result_collector #(
    parameter int ACCUM_SIZE = 64,
    parameter int NUM_FEAT   = 2,
    parameter int NUM_SV     = 3,
    parameter int NUM_INST   = 2,
    localparam int IW        = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic signed [ACCUM_SIZE-1:0]   bias,
    input  logic                           mac_valid,
    input  logic signed [ACCUM_SIZE-1:0]   mac_result,
    input  logic                           out_ready,
    output logic [NUM_INST*ACCUM_SIZE-1:0] results,
    output logic [NUM_INST-1:0]            labels,
    output logic                           res_valid,
    output logic                           busy,
    output logic [IW-1:0]                  inst_idx,
    output logic                           start_err
);

    localparam int FILL_BEATS = NUM_SV * NUM_FEAT;
    localparam int CW         = $clog2(FILL_BEATS + 1);
    localparam logic signed [ACCUM_SIZE-1:0] SAT_MAX = {1'b0, {(ACCUM_SIZE-1){1'b1}}};
    localparam logic signed [ACCUM_SIZE-1:0] SAT_MIN = {1'b1, {(ACCUM_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t                        state_q;
    logic [CW-1:0]                 cnt_q;
    logic [IW-1:0]                 idx_q;
    logic signed [ACCUM_SIZE-1:0]  bias_q;
    logic signed [ACCUM_SIZE-1:0]  results_q [NUM_INST];
    logic                          res_valid_q;
    logic                          busy_q;
    logic                          start_err_q;
    logic signed [ACCUM_SIZE-1:0]  capture_d;

    // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
    function automatic logic signed [ACCUM_SIZE-1:0] sat_add(
        input logic signed [ACCUM_SIZE-1:0] a,
        input logic signed [ACCUM_SIZE-1:0] b
    );
        logic [ACCUM_SIZE:0] sum;
        sum = {a[ACCUM_SIZE-1], a} + {b[ACCUM_SIZE-1], b};
        if (sum[ACCUM_SIZE] != sum[ACCUM_SIZE-1])
            return sum[ACCUM_SIZE] ? SAT_MIN : SAT_MAX;
        return sum[ACCUM_SIZE-1:0];
    endfunction

    assign capture_d = sat_add(mac_result, bias_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            bias_q      <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            start_err_q <= 1'b0;
            // NOTE: the result store is visible at the ports, so it is reset like any other state.
            for (int i = 0; i < NUM_INST; i++) results_q[i] <= '0;
        end else begin
            start_err_q <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                idx_q       <= '0;
                res_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            bias_q  <= bias;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= FILL;
                            for (int i = 0; i < NUM_INST; i++) results_q[i] <= '0;
                        end
                    end
                    FILL: begin
                        if (start) start_err_q <= 1'b1;
                        if (mac_valid) begin
                            if (cnt_q == CW'(FILL_BEATS - 1)) begin
                                results_q[0] <= capture_d;
                                cnt_q        <= '0;
                                if (NUM_INST == 1) begin
                                    res_valid_q <= 1'b1;
                                    busy_q      <= 1'b0;
                                    state_q     <= DONE;
                                end else begin
                                    idx_q   <= IW'(1);
                                    state_q <= STREAM;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    STREAM: begin
                        if (start) start_err_q <= 1'b1;
                        if (mac_valid) begin
                            if (cnt_q == CW'(NUM_SV - 1)) begin
                                cnt_q <= '0;
                                for (int i = 0; i < NUM_INST; i++)
                                    if (idx_q == IW'(i)) results_q[i] <= capture_d;
                                if (idx_q == IW'(NUM_INST - 1)) begin
                                    res_valid_q <= 1'b1;
                                    busy_q      <= 1'b0;
                                    state_q     <= DONE;
                                end else begin
                                    idx_q <= idx_q + 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            res_valid_q <= 1'b0;
                            if (start) begin
                                bias_q  <= bias;
                                cnt_q   <= '0;
                                idx_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= FILL;
                                for (int i = 0; i < NUM_INST; i++) results_q[i] <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (start) begin
                            start_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_INST; g++) begin : g_out
        assign results[g*ACCUM_SIZE +: ACCUM_SIZE] = results_q[g];
        assign labels[g] = ~results_q[g][ACCUM_SIZE-1];
    end

    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign inst_idx  = idx_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_svm_result_collector.sv
// Randomized self-checking bench for svm_result_collector against an arithmetic
// model of the batch: which beat feeds which instance, saturated bias add, timing.
module tb_svm_result_collector;

    localparam int W     = 64;
    localparam int NF    = 2;
    localparam int NS    = 3;
    localparam int NI    = 2;
    localparam int FILL  = NS * NF;
    localparam int TOTAL = FILL + (NI - 1) * NS;
    localparam int IW    = (NI > 1) ? $clog2(NI) : 1;
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic mac_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [W-1:0] bias = '0;
    logic signed [W-1:0] mac_result = '0;
    logic [NI*W-1:0] results;
    logic [NI-1:0]   labels;
    logic            res_valid;
    logic            busy;
    logic [IW-1:0]   inst_idx;
    logic            start_err;

    int total = 0;
    int bad   = 0;

    logic signed [W-1:0] beat_data [TOTAL];
    int                  stall_n   [TOTAL];
    logic signed [W-1:0] exp_res   [NI];
    logic [NI-1:0]       exp_lab;

    svm_result_collector #(.ACCUM_SIZE(W), .NUM_FEAT(NF), .NUM_SV(NS), .NUM_INST(NI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
        .mac_valid(mac_valid), .mac_result(mac_result), .out_ready(out_ready),
        .results(results), .labels(labels), .res_valid(res_valid), .busy(busy),
        .inst_idx(inst_idx), .start_err(start_err)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] ref_sat(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] ea, eb, s, mx, mn;
        ea = a; eb = b; mx = SMAX; mn = SMIN;
        s = ea + eb;
        if (s > mx) return SMAX;
        if (s < mn) return SMIN;
        return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] res_of(input int i);
        return results[i*W +: W];
    endfunction

    function automatic logic signed [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random_beats(input int max_stall);
        for (int n = 0; n < TOTAL; n++) begin
            beat_data[n] = rnd64();
            stall_n[n]   = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
        end
    endtask

    // Drives start, then stop_after beats with stalls; err_at marks a beat that also carries start.
    task automatic run_batch(input logic signed [W-1:0] b, input int stop_after,
                             input int err_at, input bit b2b, output int cycles);
        bit chk_clear;
        for (int k = 0; k < NI; k++) begin
            exp_res[k] = ref_sat(beat_data[FILL - 1 + k * NS], b);
            exp_lab[k] = (exp_res[k] >= 0);
        end
        start = 1'b1; bias = b; out_ready = b2b; mac_valid = 1'b0;
        step();
        start = 1'b0; out_ready = 1'b0; bias = rnd64();
        total++;
        if (busy !== 1'b1 || res_valid !== 1'b0 || results !== '0 || inst_idx !== '0 || start_err !== 1'b0) begin
            bad++;
            $display("FAIL batch_start: busy=%0b res_valid=%0b inst_idx=%0d start_err=%0b results=%h, required busy=1 res_valid=0 inst_idx=0 start_err=0 results=0",
                     busy, res_valid, inst_idx, start_err, results);
        end
        cycles = 0;
        chk_clear = 1'b0;
        for (int n = 0; n < stop_after; n++) begin
            mac_valid = 1'b1; mac_result = beat_data[n]; start = (n == err_at);
            step();
            cycles++;
            mac_valid = 1'b0; start = 1'b0; mac_result = rnd64();
            if (chk_clear) begin
                chk_clear = 1'b0;
                total++;
                if (start_err !== 1'b0) begin
                    bad++;
                    $display("FAIL start_err_width: start_err=%0b, required 0", start_err);
                end
            end
            if (n == err_at) begin
                chk_clear = 1'b1;
                total++;
                if (start_err !== 1'b1) begin
                    bad++;
                    $display("FAIL start_err_pulse: start_err=%0b, required 1", start_err);
                end
            end
            if (n == FILL - 1) begin
                total++;
                if (res_of(0) !== exp_res[0] || res_of(1) !== '0 || inst_idx !== IW'(1) ||
                    res_valid !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL fill_capture: r0=%0d r1=%0d idx=%0d res_valid=%0b busy=%0b, required r0=%0d r1=0 idx=1 res_valid=0 busy=1",
                             res_of(0), res_of(1), inst_idx, res_valid, busy, exp_res[0]);
                end
            end else if (n == TOTAL - 1) begin
                total++;
                if (res_valid !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL done_flags: res_valid=%0b busy=%0b, required res_valid=1 busy=0", res_valid, busy);
                end
                for (int k = 0; k < NI; k++) begin
                    total++;
                    if (res_of(k) !== exp_res[k]) begin
                        bad++;
                        $display("FAIL result[%0d]: got %0d, required %0d", k, res_of(k), exp_res[k]);
                    end
                end
                total++;
                if (labels !== exp_lab) begin
                    bad++;
                    $display("FAIL labels: got %b, required %b", labels, exp_lab);
                end
            end else begin
                total++;
                if (res_valid !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL mid_batch beat %0d: res_valid=%0b busy=%0b, required res_valid=0 busy=1", n, res_valid, busy);
                end
            end
            if (n < TOTAL - 1) begin
                for (int s = 0; s < stall_n[n]; s++) begin
                    step();
                    cycles++;
                    mac_result = rnd64();
                    if (chk_clear) begin
                        chk_clear = 1'b0;
                        total++;
                        if (start_err !== 1'b0) begin
                            bad++;
                            $display("FAIL start_err_width: start_err=%0b, required 0", start_err);
                        end
                    end
                end
            end
        end
    endtask

    task automatic release_batch();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL release: res_valid=%0b busy=%0b, required 0 0", res_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        total++;
        if (results !== '0 || labels !== '1 || res_valid !== 1'b0 || busy !== 1'b0 ||
            inst_idx !== '0 || start_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: results=%h labels=%b res_valid=%0b busy=%0b idx=%0d start_err=%0b, required 0 11 0 0 0 0",
                     results, labels, res_valid, busy, inst_idx, start_err);
        end
        step();
        rst_n = 1'b1;
        mac_valid = 1'b1; mac_result = rnd64();
        step();
        step();
        mac_valid = 1'b0;
        total++;
        if (results !== '0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignores_mac: results=%h busy=%0b res_valid=%0b, required 0 0 0", results, busy, res_valid);
        end
    endtask

    task automatic test_basic(output int base_cycles);
        fill_random_beats(0);
        beat_data[5] = 100;
        beat_data[8] = 10;
        run_batch(-40, TOTAL, -1, 1'b0, base_cycles);
        total++;
        if (res_of(0) !== 64'sd60 || res_of(1) !== -64'sd30 || labels !== 2'b01) begin
            bad++;
            $display("FAIL basic_values: r0=%0d r1=%0d labels=%b, required 60 -30 01", res_of(0), res_of(1), labels);
        end
        // DONE holds through mac beats and a rejected start.
        for (int c = 0; c < 3; c++) begin
            mac_valid = 1'b1; mac_result = rnd64(); start = (c == 0); bias = rnd64();
            step();
            mac_valid = 1'b0; start = 1'b0;
            total++;
            if (res_valid !== 1'b1 || res_of(0) !== exp_res[0] || res_of(1) !== exp_res[1] ||
                start_err !== (c == 0)) begin
                bad++;
                $display("FAIL done_hold cycle %0d: res_valid=%0b r0=%0d r1=%0d start_err=%0b, required 1 %0d %0d %0b",
                         c, res_valid, res_of(0), res_of(1), start_err, exp_res[0], exp_res[1], (c == 0));
            end
        end
        release_batch();
    endtask

    task automatic test_stalls(input int base_cycles);
        int cyc;
        for (int n = 0; n < TOTAL; n++) stall_n[n] = 0;
        stall_n[1] = 2; stall_n[5] = 2; stall_n[7] = 2;
        run_batch(-40, TOTAL, -1, 1'b0, cyc);
        total++;
        if (cyc !== base_cycles + 6) begin
            bad++;
            $display("FAIL stall_latency: cycles=%0d, required %0d", cyc, base_cycles + 6);
        end
        release_batch();
    endtask

    task automatic test_saturation();
        int cyc;
        fill_random_beats(1);
        beat_data[5] = SMAX;
        run_batch(5, TOTAL, -1, 1'b0, cyc);
        total++;
        if (res_of(0) !== SMAX || labels[0] !== 1'b1) begin
            bad++;
            $display("FAIL sat_pos: r0=%0d label0=%0b, required %0d 1", res_of(0), labels[0], SMAX);
        end
        release_batch();
        fill_random_beats(1);
        beat_data[8] = SMIN;
        run_batch(-5, TOTAL, -1, 1'b0, cyc);
        total++;
        if (res_of(1) !== SMIN || labels[1] !== 1'b0) begin
            bad++;
            $display("FAIL sat_neg: r1=%0d label1=%0b, required %0d 0", res_of(1), labels[1], SMIN);
        end
        release_batch();
    endtask

    task automatic test_start_err_back_to_back();
        int cyc;
        fill_random_beats(1);
        run_batch(rnd64(), TOTAL, 7, 1'b0, cyc);
        fill_random_beats(1);
        run_batch(rnd64(), TOTAL, -1, 1'b1, cyc);
        release_batch();
    endtask

    task automatic test_abort();
        int cyc;
        fill_random_beats(0);
        beat_data[5] = 100;
        run_batch(-40, 7, -1, 1'b0, cyc);
        abort = 1'b1; start = 1'b1; mac_valid = 1'b1; mac_result = rnd64(); bias = rnd64();
        step();
        abort = 1'b0; start = 1'b0; mac_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || start_err !== 1'b0 || inst_idx !== '0 ||
            res_of(0) !== 64'sd60 || res_of(1) !== '0) begin
            bad++;
            $display("FAIL abort_state: busy=%0b res_valid=%0b start_err=%0b idx=%0d r0=%0d r1=%0d, required 0 0 0 0 60 0",
                     busy, res_valid, start_err, inst_idx, res_of(0), res_of(1));
        end
        step();
        total++;
        if (busy !== 1'b0 || start_err !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_drop_start: busy=%0b start_err=%0b res_valid=%0b, required 0 0 0", busy, start_err, res_valid);
        end
        fill_random_beats(2);
        run_batch(rnd64(), TOTAL, -1, 1'b0, cyc);
        release_batch();
    endtask

    task automatic test_reset_mid();
        int cyc;
        fill_random_beats(1);
        run_batch(rnd64(), 7, -1, 1'b0, cyc);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (results !== '0 || labels !== '1 || res_valid !== 1'b0 || busy !== 1'b0 ||
            inst_idx !== '0 || start_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: results=%h labels=%b res_valid=%0b busy=%0b idx=%0d start_err=%0b, required 0 11 0 0 0 0",
                     results, labels, res_valid, busy, inst_idx, start_err);
        end
        step();
        rst_n = 1'b1;
        step();
        fill_random_beats(1);
        run_batch(rnd64(), TOTAL, -1, 1'b0, cyc);
        release_batch();
    endtask

    task automatic test_random();
        int cyc;
        logic signed [W-1:0] b;
        for (int t = 0; t < 8; t++) begin
            fill_random_beats(2);
            for (int k = 0; k < NI; k++) begin
                case ($urandom_range(0, 3))
                    0: beat_data[FILL - 1 + k * NS] = SMAX;
                    1: beat_data[FILL - 1 + k * NS] = SMIN;
                    default: ;
                endcase
            end
            case ($urandom_range(0, 3))
                0: b = SMAX;
                1: b = SMIN;
                2: b = $signed(W'($urandom_range(0, 200))) - 100;
                default: b = rnd64();
            endcase
            run_batch(b, TOTAL, -1, 1'b0, cyc);
            release_batch();
        end
    endtask

    initial begin
        int base_cycles;
        test_reset();
        test_basic(base_cycles);
        test_stalls(base_cycles);
        test_saturation();
        test_start_err_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
